// File: rtl/aes_model_pack.sv
// Shared AES model constants and helpers: S-box, round constants, expander
// state encoding and the RotWord/SubWord helper used by key expansion.
package aes_model_pack;

  localparam logic [7:0] SUB_BYTES_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON_TABLE [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    EXP_IDLE = 1'b0,
    EXP_EMIT = 1'b1
  } exp_state_t;

  // Words keep FIPS byte 0 in bits [7:0], so RotWord is a right rotate by one byte.
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] rot;
    logic [31:0] res;
    rot = {w[7:0], w[31:8]};
    res = 32'h0000_0000;
    for (int j = 0; j < 4; j++) begin
      res[8*j +: 8] = SUB_BYTES_TABLE[rot[8*j +: 8]];
    end
    return res;
  endfunction

  function automatic logic [7:0] rcon_for_round(input logic [3:0] round);
    logic [7:0] rc;
    if ((round >= 4'd1) && (round <= 4'd10)) begin
      rc = RCON_TABLE[round];
    end else begin
      rc = 8'h00;
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-schedule round: derives the next round key from the
// current one and its round constant, purely combinationally.
module aes_key_round_step
  import aes_model_pack::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] t_s;
  logic [31:0] w0_s;
  logic [31:0] w1_s;
  logic [31:0] w2_s;
  logic [31:0] w3_s;

  // chained word XORs of the FIPS-197 schedule
  always_comb begin
    t_s      = sub_rot_word(key[127:96]) ^ {24'h00_0000, rcon};
    w0_s     = key[31:0]   ^ t_s;
    w1_s     = key[63:32]  ^ w0_s;
    w2_s     = key[95:64]  ^ w1_s;
    w3_s     = key[127:96] ^ w2_s;
    next_key = {w3_s, w2_s, w1_s, w0_s};
  end

endmodule

// File: rtl/aes_key_expander.sv
// Streaming AES-128 key expander: accepts a cipher key and emits round keys
// 0..NUM_ROUNDS as valid/ready beats, one derivation step per handshake.
module aes_key_expander
  import aes_model_pack::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy
);

  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 10)) begin : g_bad_num_rounds
    $error("aes_key_expander: NUM_ROUNDS must be within 1..10");
  end

  localparam logic [3:0] LAST_INDEX = 4'(NUM_ROUNDS);

  exp_state_t   state_r;
  exp_state_t   state_s;
  logic [127:0] rk_data_r;
  logic [127:0] rk_data_s;
  logic [127:0] next_key_s;
  logic [3:0]   rk_index_r;
  logic [3:0]   rk_index_s;
  logic [3:0]   next_index_s;
  logic         rk_valid_r;
  logic         rk_valid_s;
  logic         rk_last_r;
  logic         rk_last_s;
  logic [7:0]   rcon_s;

  assign next_index_s = rk_index_r + 4'd1;
  assign rcon_s       = rcon_for_round(next_index_s);

  aes_key_round_step u_round_step (
    .key      (rk_data_r),
    .rcon     (rcon_s),
    .next_key (next_key_s)
  );

  // state and round-key registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= EXP_IDLE;
      rk_data_r  <= 128'h0;
      rk_index_r <= 4'd0;
      rk_valid_r <= 1'b0;
      rk_last_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rk_data_r  <= rk_data_s;
      rk_index_r <= rk_index_s;
      rk_valid_r <= rk_valid_s;
      rk_last_r  <= rk_last_s;
    end
  end

  // next-state logic; every register holds unless a handshake moves it
  always_comb begin
    state_s    = state_r;
    rk_data_s  = rk_data_r;
    rk_index_s = rk_index_r;
    rk_valid_s = rk_valid_r;
    rk_last_s  = rk_last_r;
    case (state_r)
      EXP_IDLE: begin
        if (key_valid) begin
          state_s    = EXP_EMIT;
          rk_data_s  = key_in;
          rk_index_s = 4'd0;
          rk_valid_s = 1'b1;
          rk_last_s  = 1'b0;
        end else begin
          rk_valid_s = 1'b0;
          rk_last_s  = 1'b0;
        end
      end
      EXP_EMIT: begin
        if (rk_ready && rk_last_r) begin
          state_s    = EXP_IDLE;
          rk_valid_s = 1'b0;
          rk_last_s  = 1'b0;
        end else if (rk_ready) begin
          rk_data_s  = next_key_s;
          rk_index_s = next_index_s;
          rk_last_s  = (next_index_s == LAST_INDEX);
        end else begin
          rk_valid_s = 1'b1;
        end
      end
      default: begin
        state_s    = EXP_IDLE;
        rk_valid_s = 1'b0;
        rk_last_s  = 1'b0;
      end
    endcase
  end

  assign key_ready = (state_r == EXP_IDLE);
  assign busy      = (state_r == EXP_EMIT);
  assign rk_data   = rk_data_r;
  assign rk_index  = rk_index_r;
  assign rk_valid  = rk_valid_r;
  assign rk_last   = rk_last_r;

endmodule
